rans_stream_ctrl: RTL and testbench

//  Sequential control around the combinational rANS alias-table decode stage (SCALE_BITS=16, byte renorm).

---
 rtl/rans_pkg.sv | 23 ++
 rtl/rans_stream_ctrl_if.sv | 25 ++
 rtl/rans_stream_ctrl.sv | 100 ++++++++++
 tb/tb_rans_stream_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rans_pkg.sv
// Shared constants for the rANS decoder: renorm bound, table geometry and
// the controller FSM encoding.
package rans_pkg;

    localparam logic [31:0] RANS_L     = 32'h0080_0000;
    localparam int          SCALE_BITS = 16;
    localparam int          LOG2NSYMS  = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_EMIT   = 3'd2;
    localparam logic [2:0] ST_RENORM = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // One byte-wise renormalisation step; the top byte falls off.
    function automatic logic [31:0] renorm_shift(
        input logic [31:0] s,
        input logic [7:0]  b
    );
        return {s[23:0], b};
    endfunction

endpackage

// File: rtl/rans_stream_ctrl_if.sv
// Byte-stream, decode-stage and symbol-sink signals of the rANS stream
// controller; master is the controller, slave is its surroundings.
interface rans_stream_ctrl_if;

    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dec_state;
    logic [31:0] dec_new_state;
    logic [7:0]  dec_sym;
    logic [7:0]  sym_out;
    logic        sym_valid;
    logic        sym_ready;

    modport master (
        input  in_byte, in_valid, dec_new_state, dec_sym, sym_ready,
        output in_ready, dec_state, sym_out, sym_valid
    );

    modport slave (
        output in_byte, in_valid, dec_new_state, dec_sym, sym_ready,
        input  in_ready, dec_state, sym_out, sym_valid
    );

endinterface

// File: rtl/rans_stream_ctrl.sv
// Sequential control around the combinational rANS decode stage: state load,
// symbol emission and byte-wise renormalisation.
import rans_pkg::*;

module rans_stream_ctrl #(
    parameter logic [31:0] RANS_L = rans_pkg::RANS_L,
    parameter int          CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_syms,
    output logic                busy,
    output logic                done,
    output logic                final_ok,
    rans_stream_ctrl_if.master  bus
);

    logic [2:0]       fsm;
    logic [31:0]      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nsyms;
    logic [1:0]       byte_idx;

    logic [CNT_W-1:0] cnt_nxt;
    logic [31:0]      shifted;
    logic             low;
    logic             last;

    assign cnt_nxt = cnt + CNT_W'(1);
    assign shifted = renorm_shift(state, bus.in_byte);
    assign low     = state < RANS_L;
    assign last    = cnt == nsyms;

    assign bus.dec_state = state;
    assign bus.sym_out   = bus.dec_sym;
    assign bus.sym_valid = fsm == ST_EMIT;
    assign bus.in_ready  = (fsm == ST_INIT) | ((fsm == ST_RENORM) & low);

    assign busy = fsm != ST_IDLE;
    assign done = fsm == ST_DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= ST_IDLE;
            state    <= '0;
            cnt      <= '0;
            nsyms    <= '0;
            byte_idx <= '0;
            final_ok <= 1'b0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (start) begin
                        nsyms    <= num_syms;
                        cnt      <= '0;
                        byte_idx <= '0;
                        final_ok <= 1'b0;
                        fsm      <= (num_syms == '0) ? ST_DONE : ST_INIT;
                    end
                end
                ST_INIT: begin
                    // Little-endian load: the first byte ends up in bits 7:0.
                    if (bus.in_valid) begin
                        state    <= {bus.in_byte, state[31:8]};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3)
                            fsm <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (bus.sym_ready) begin
                        state <= bus.dec_new_state;
                        cnt   <= cnt_nxt;
                        if (bus.dec_new_state < RANS_L)
                            fsm <= ST_RENORM;
                        else if (cnt_nxt == nsyms)
                            fsm <= ST_DONE;
                    end
                end
                ST_RENORM: begin
                    // Leave as soon as the shifted state is in range.
                    if (!low) begin
                        fsm <= last ? ST_DONE : ST_EMIT;
                    end else if (bus.in_valid) begin
                        state <= shifted;
                        if (shifted >= RANS_L)
                            fsm <= last ? ST_DONE : ST_EMIT;
                    end
                end
                ST_DONE: begin
                    final_ok <= state == RANS_L;
                    fsm      <= ST_IDLE;
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rans_stream_ctrl.sv
// Directed bench for rans_stream_ctrl with a stub decode stage and a
// scoreboard of expected symbols/states.
module tb_rans_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] num_syms = '0;
    logic        busy;
    logic        done;
    logic        final_ok;
    logic        mode = 1'b0;
    logic [31:0] nxt = '0;

    int passed = 0;
    int total = 0;
    int bytes_taken = 0;
    int syms_seen = 0;
    int b0;

    typedef struct packed {
        logic [7:0]  sym;
        logic [31:0] st;
    } exp_t;

    exp_t q[$];

    rans_stream_ctrl_if bus();

    always #5 clk = ~clk;

    rans_stream_ctrl #(
        .RANS_L(32'h0080_0000),
        .CNT_W (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .num_syms(num_syms),
        .busy    (busy),
        .done    (done),
        .final_ok(final_ok),
        .bus     (bus.master)
    );

    function automatic logic [7:0] sym_of(input logic [31:0] s);
        return s[7:0] ^ s[31:24];
    endfunction

    // Decode-stage stub
    assign bus.dec_sym       = sym_of(bus.dec_state);
    assign bus.dec_new_state = mode ? bus.dec_state + 32'h0111_0000 : nxt;

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("excl", {31'd0, bus.in_ready & bus.sym_valid}, 32'd0);
            if (bus.in_valid && bus.in_ready)
                bytes_taken++;
            if (bus.sym_valid && bus.sym_ready) begin
                syms_seen++;
                if (q.size() == 0) begin
                    total++;
                    $error("FAIL sb_empty: observed extra symbol %h expected none",
                           bus.sym_out);
                end else begin
                    e = q.pop_front();
                    check("sb_sym", {24'd0, bus.sym_out}, {24'd0, e.sym});
                    check("sb_state", bus.dec_state, e.st);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] n);
        num_syms = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        bus.in_byte = b;
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            tick();
            k++;
        end
        if (k == 20) begin
            total++;
            $error("FAIL byte_timeout: observed in_ready=0 expected 1");
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send4(input logic [31:0] w, input bit gap);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(v[7:0]);
            v = v >> 8;
            if (gap && i < 3) begin
                bus.in_byte = 8'hEE;
                tick();
            end
        end
    endtask

    initial begin
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] s3;
        bus.in_valid = 1'b0;
        bus.in_byte = '0;
        bus.sym_ready = 1'b0;

        tick();
        tick();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_sym_valid", {31'd0, bus.sym_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_final_ok", {31'd0, final_ok}, 32'd0);
        check("rst_dec_state", bus.dec_state, 32'd0);
        rst = 1'b0;
        tick();

        // Load with gaps, backpressure, then one symbol without renorm
        b0 = bytes_taken;
        pulse_start(32'd1);
        check("t2_busy", {31'd0, busy}, 32'd1);
        check("t2_in_ready", {31'd0, bus.in_ready}, 32'd1);
        nxt = 32'h0100_0000;
        q.push_back('{sym: sym_of(32'h1234_5678), st: 32'h1234_5678});
        send4(32'h1234_5678, 1'b1);
        check("t2_state", bus.dec_state, 32'h1234_5678);
        check("t2_sym_valid", {31'd0, bus.sym_valid}, 32'd1);
        check("t2_in_ready0", {31'd0, bus.in_ready}, 32'd0);
        check("t2_bytes", bytes_taken - b0, 32'd4);
        bus.in_valid = 1'b1;
        bus.in_byte = 8'h99;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_sym_valid", {31'd0, bus.sym_valid}, 32'd1);
            check("t5_sym_out", {24'd0, bus.sym_out},
                  {24'd0, sym_of(32'h1234_5678)});
            check("t5_state", bus.dec_state, 32'h1234_5678);
        end
        bus.sym_ready = 1'b1;
        tick();
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_state", bus.dec_state, 32'h0100_0000);
        tick();
        check("t3_done_pulse", {31'd0, done}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_final_ok", {31'd0, final_ok}, 32'd0);
        check("t3_bytes", bytes_taken - b0, 32'd4);
        bus.in_valid = 1'b0;

        // Two-byte renorm
        b0 = bytes_taken;
        pulse_start(32'd1);
        nxt = 32'h0000_0080;
        q.push_back('{sym: sym_of(32'h4433_2211), st: 32'h4433_2211});
        send4(32'h4433_2211, 1'b0);
        tick();
        check("t4_low", bus.dec_state, 32'h0000_0080);
        check("t4_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("t4_sym_valid", {31'd0, bus.sym_valid}, 32'd0);
        send_byte(8'hAA);
        check("t4_b1", bus.dec_state, 32'h0000_80AA);
        check("t4_busy", {31'd0, busy}, 32'd1);
        send_byte(8'hBB);
        check("t4_b2", bus.dec_state, 32'h0080_AABB);
        check("t4_done", {31'd0, done}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_byte = 8'hCC;
        tick();
        check("t4_final_ok", {31'd0, final_ok}, 32'd0);
        check("t4_bytes", bytes_taken - b0, 32'd6);
        bus.in_valid = 1'b0;

        // Renorm landing exactly on RANS_L
        pulse_start(32'd1);
        nxt = 32'h0000_8000;
        q.push_back('{sym: sym_of(32'h0A0B_0C0D), st: 32'h0A0B_0C0D});
        send4(32'h0A0B_0C0D, 1'b0);
        tick();
        check("t4v_low", bus.dec_state, 32'h0000_8000);
        send_byte(8'h00);
        check("t4v_state", bus.dec_state, 32'h0080_0000);
        check("t4v_done", {31'd0, done}, 32'd1);
        tick();
        check("t4v_final_ok", {31'd0, final_ok}, 32'd1);
        tick();
        check("t4v_hold", {31'd0, final_ok}, 32'd1);
        check("t4v_busy", {31'd0, busy}, 32'd0);

        // Empty block
        b0 = bytes_taken;
        bus.in_valid = 1'b1;
        bus.in_byte = 8'h55;
        pulse_start(32'd0);
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_final_clr", {31'd0, final_ok}, 32'd0);
        check("t6_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        check("t6_done_pulse", {31'd0, done}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_bytes", bytes_taken - b0, 32'd0);
        bus.in_valid = 1'b0;

        // Three symbols back to back
        mode = 1'b1;
        s0 = 32'h0403_0201;
        s1 = s0 + 32'h0111_0000;
        s2 = s1 + 32'h0111_0000;
        s3 = s2 + 32'h0111_0000;
        q.push_back('{sym: sym_of(s0), st: s0});
        q.push_back('{sym: sym_of(s1), st: s1});
        q.push_back('{sym: sym_of(s2), st: s2});
        pulse_start(32'd3);
        send4(s0, 1'b0);
        check("t6_v0", {31'd0, bus.sym_valid}, 32'd1);
        check("t6_s0", bus.dec_state, s0);
        tick();
        check("t6_v1", {31'd0, bus.sym_valid}, 32'd1);
        check("t6_s1", bus.dec_state, s1);
        tick();
        check("t6_v2", {31'd0, bus.sym_valid}, 32'd1);
        check("t6_s2", bus.dec_state, s2);
        tick();
        check("t6_done3", {31'd0, done}, 32'd1);
        check("t6_s3", bus.dec_state, s3);
        tick();
        check("t6_idle", {31'd0, busy}, 32'd0);
        mode = 1'b0;

        // Reset in the middle of renorm
        nxt = 32'h0000_0080;
        q.push_back('{sym: sym_of(32'hDEAD_BEEF), st: 32'hDEAD_BEEF});
        pulse_start(32'd1);
        send4(32'hDEAD_BEEF, 1'b0);
        tick();
        send_byte(8'h12);
        check("t1_pre", bus.dec_state, 32'h0000_8012);
        rst = 1'b1;
        #1;
        check("t1_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("t1_sym_valid", {31'd0, bus.sym_valid}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_state", bus.dec_state, 32'd0);
        tick();
        check("t1_state_edge", bus.dec_state, 32'd0);
        rst = 1'b0;
        b0 = bytes_taken;
        bus.in_valid = 1'b1;
        tick();
        tick();
        check("t1_idle", {31'd0, busy}, 32'd0);
        check("t1_no_bytes", bytes_taken - b0, 32'd0);
        bus.in_valid = 1'b0;

        check("sb_left", q.size(), 32'd0);
        check("sym_count", syms_seen, 32'd7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
